// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select with delay-slot redirects, IF/ID register.
// Optional fetch-address range check is enabled with `define PC_RANGE_CHECK_EN.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  npc_sel,
    input  logic [15:0] br_offset,
    input  logic [25:0] j_index,
    input  logic [31:0] jr_target,
    input  logic [31:0] instr_in,
    output logic [9:0]  im_addr,
    output logic [31:0] pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc_plus4,
    output logic        id_valid,
    output logic        fetch_err
);

    logic [31:0] pc_plus4;
    logic [31:0] br_target;
    logic [31:0] j_target;
    logic [31:0] npc;
    logic        npc_ok;
    logic        halted;

    assign im_addr   = pc[11:2];
    assign pc_plus4  = pc + 32'd4;
    assign br_target = id_pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign j_target  = {id_pc_plus4[31:28], j_index, 2'b00};

    // Redirects come from the instruction in ID; a bubble there must never redirect.
    always_comb begin
        npc = pc_plus4;
        if (id_valid) begin
            unique case (npc_sel)
                2'b00:   npc = pc_plus4;
                2'b01:   npc = br_target;
                2'b10:   npc = j_target;
                2'b11:   npc = jr_target;
                default: npc = pc_plus4;
            endcase
        end
    end

`ifdef PC_RANGE_CHECK_EN
    localparam logic [32:0] PC_LIMIT = {1'b0, PC_RESET} + 33'(4 * IM_WORDS);

    logic err_q;

    assign npc_ok    = (npc[1:0] == 2'b00) && (npc >= PC_RESET) && ({1'b0, npc} < PC_LIMIT);
    assign halted    = err_q;
    assign fetch_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (!stall && !err_q && !npc_ok) begin
            err_q <= 1'b1;
        end
    end
`else
    // The 10-bit word address cannot reach past 1024 words; larger depths simply alias.
    if (IM_WORDS > 1024) begin : g_im_words_alias
    end

    assign npc_ok    = 1'b1;
    assign halted    = 1'b0;
    assign fetch_err = 1'b0;
`endif

    // Once halted by a bad target, the PC stays frozen and IF/ID only takes bubbles.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= PC_RESET;
            id_instr    <= 32'd0;
            id_pc_plus4 <= 32'd0;
            id_valid    <= 1'b0;
        end else begin
            if (!stall && !halted && npc_ok) begin
                pc <= npc;
            end
            if (flush || (!stall && halted)) begin
                id_instr    <= 32'd0;
                id_pc_plus4 <= 32'd0;
                id_valid    <= 1'b0;
            end else if (!stall) begin
                id_instr    <= instr_in;
                id_pc_plus4 <= pc_plus4;
                id_valid    <= 1'b1;
            end
        end
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined MIPS core.
- Holds the program counter and drives the word address into the instruction memory.
- Computes the next PC from ID-stage redirect requests (branch, j/jal, jr) under delay-slot semantics.
- Registers the fetched word into the IF/ID pipeline register, with stall and flush control.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_WORDS, 1024, instruction memory depth in words; used only by the optional range check.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard stall from the hazard unit; freezes PC and IF/ID.
- flush  input  1  clears IF/ID to a bubble.
- npc_sel  input  2  next-PC select from ID decode: 00 = PC+4, 01 = branch taken, 10 = j/jal, 11 = jr.
- br_offset  input  16  branch immediate of the instruction in ID.
- j_index  input  26  jump index of the instruction in ID.
- jr_target  input  32  forwarded rs value for jr.
- instr_in  input  32  instruction word returned by instruction memory.
- im_addr  output  10  word address to instruction memory, equal to pc[11:2].
- pc  output  32  current fetch PC.
- id_instr  output  32  IF/ID instruction register.
- id_pc_plus4  output  32  IF/ID PC+4 register.
- id_valid  output  1  IF/ID holds a real instruction.
- fetch_err  output  1  sticky fetch-address error (tied 0 unless PC_RANGE_CHECK_EN).

Behaviour:
- Reset (synchronous, priority over everything):
  - pc <= PC_RESET.
  - id_instr <= 0, id_pc_plus4 <= 0, id_valid <= 0, fetch_err <= 0.
- im_addr = pc[11:2], combinational. Instruction memory read is combinational, so instr_in for PC n is valid in the same cycle and is latched into IF/ID at the next edge (1-cycle fetch latency).
- Next-PC computation (32-bit, overflow wraps modulo 2^32):
  - 00: pc + 4.
  - 01: id_pc_plus4 + (sign_ext(br_offset) << 2).
  - 10: {id_pc_plus4[31:28], j_index, 2'b00}.
  - 11: jr_target.
- Redirect targets are relative to the instruction in ID, so the instruction already fetched behind it (the delay slot) is always executed. No automatic flush on a taken branch.
- Per-edge update priority:
  - reset > stall > normal.
  - stall=1: pc holds and redirects are ignored. The ID instruction stays put, so the redirect is re-presented and applied on the first unstalled cycle.
  - stall=1 and flush=0: IF/ID holds.
  - flush=1 (with or without stall): IF/ID <= {0, 0, valid=0}. pc follows the stall/normal rule.
  - normal (stall=0, flush=0): pc <= next PC; id_instr <= instr_in; id_pc_plus4 <= pc+4; id_valid <= 1.
- Misaligned jr_target (bits[1:0] != 0): without the macro, loaded as-is; im_addr ignores the low bits.
- npc_sel is ignored whenever id_valid=0; next PC is forced to pc+4. This prevents bubbles from redirecting.

Optional Feature:
- Macro: PC_RANGE_CHECK_EN.
- Defined: a next PC that is misaligned, or outside [PC_RESET, PC_RESET + 4*IM_WORDS), is not loaded:
  - fetch_err <= 1, sticky until reset.
  - pc freezes at its current value.
  - IF/ID is loaded with bubbles (id_valid=0) from the following edge onward.
- Undefined: no check; fetch_err is constant 0; out-of-range addresses wrap through pc[11:2].

Test Plan:
- Reset then 3 unstalled cycles -> pc 0x3000, 0x3004, 0x3008, 0x300C; im_addr 0x000..0x003; id_pc_plus4 = 0x3004 after the first edge; id_valid = 1.
- beq in ID at 0x3008 (id_pc_plus4 = 0x300C), npc_sel=01, br_offset=0xFFFE -> next pc = 0x3004; the delay-slot instruction at 0x300C still enters IF/ID with id_valid=1.
- j with j_index=0x0000C10, id_pc_plus4=0x3010 -> next pc = 0x0000_3040; jr with jr_target=0x3100 -> next pc = 0x3100.
- stall=1 for 2 cycles during npc_sel=01 -> pc and IF/ID unchanged for both cycles; redirect applied on the first cycle after stall drops.
- flush=1 with stall=1 -> id_instr=0, id_valid=0, pc unchanged; reset asserted mid-stall -> pc=0x3000 on the next edge.
- PC_RANGE_CHECK_EN defined, jr_target=0x5000 -> fetch_err=1, pc holds, id_valid=0 on subsequent cycles; macro undefined -> pc=0x5000, im_addr=0x000, fetch_err=0.
